rtc_field_counters: RTL and testbench
=====================================

# rtc_field_counters

Holding-register bank for the six RTC date/time fields edited by the write FSM. It consumes the level-style `count_*UP`/`count_*DW` strobes and converts each rising edge into a single BCD increment or decrement with per-field wrap-around and calendar-correct day limits. It presents the current BCD values to the RTC bus write path and the display. A parallel load path preloads the bank from an RTC read before editing starts.

## Interface
Parameters:
- `LEAP_EN`, default 1: enables the February-29 rule (year mod 4 == 0, century 2000–2099); when 0, February is always 28 days.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `count_segUP`, `count_minUP`, `count_hourUP`, `count_dayUP`, `count_monthUP`, `count_yearUP` in 1 each: increment requests, level (may stay high many cycles).
- `count_segDW`, `count_minDW`, `count_hourDW`, `count_dayDW`, `count_monthDW`, `count_yearDW` in 1 each: decrement requests, level.
- `load` in 1: one-cycle preload strobe.
- `load_data` in 48: BCD {year, month, day, hour, min, seg}, 8 bits each, year in [47:40].
- `seg_bcd`, `min_bcd`, `hour_bcd`, `day_bcd`, `month_bcd`, `year_bcd` out 8 each: current field values, registered.
- `changed` out 1: one-cycle pulse after any button-driven field update.

## Operation
- Reset values: seg 0x00, min 0x00, hour 0x00, day 0x01, month 0x01, year 0x00; `changed` 0.
- Edge detection: each of the 12 request inputs is registered; an event is input==1 while its previous sample==0. Holding an input high yields exactly one step.
- Per field, UP event and DW event in the same cycle: no change for that field.
- Ranges, all BCD with both digits always valid:
  - seg: 00–59, wraps 59→00 on UP and 00→59 on DW.
  - min: 00–59, same wrap as seg.
  - hour: 00–23, same wrap pattern.
  - day: 01–dmax.
  - month: 01–12.
  - year: 00–99.
- dmax is 31 except:
  - months 04, 06, 09, 11: 30;
  - month 02: 29 if `LEAP_EN` and year mod 4 == 0, else 28.
- No carry or borrow between fields; this is setting mode, so seg 59→00 does not touch min.
- Day clamp: when month or year changes and current day > new dmax, day is set to the new dmax in the same cycle. Example: 31 Mar with month DW gives 29 Feb in year 24, or 28 Feb in year 23.
- Events on several different fields in one cycle: each updates independently. The day clamp uses the post-update month and year; a simultaneous day event is applied first, then the clamp.
- `load` has priority over all events in that cycle. Each loaded field is validated:
  - invalid BCD digit or out of range: that field takes its reset value;
  - day: validated against dmax of the loaded month and year, clamped to dmax if above it.
- `load` does not assert `changed`. Edge-detect history is still updated during a load cycle, so a level held through the load produces no later event.
- `reset` mid-sequence: all fields and edge history return to reset values on that edge. An input still high afterwards does not count as an event until it falls and rises again; history resets to 1 for inputs high at reset.

## Timing
- Event sampled at clock edge k (input high at k, low at k−1): the field register and `changed` update at edge k and are visible in cycle k+1.
- `changed` is high exactly one cycle per edge k that contained at least one applied step. It stays low if all events cancelled, e.g. UP+DW on the same field.
- `load` at edge k: outputs reflect the validated `load_data` in cycle k+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `rtc_pkg`:
  - field index constants (SEG..YEAR);
  - BCD range limits (8'h59, 8'h23, 8'h12, 8'h99);
  - reset values;
  - the `dmax(month, year)` function;
  - BCD validity check.
- Sub-module `bcd_field_step`: one 8-bit BCD register with min/max bound inputs, up/down event inputs, and load/validate. Instantiated six times; the day instance takes dmax as its max bound, plus the clamp input.
- Top level holds the edge-detect registers, the dmax computation and the `changed` OR-reduction.

## Test plan
- Reset, then `count_segUP` held high for 10 cycles: seg goes 0x00→0x01 once; `changed` pulses once.
- Load seg 0x59, then a segUP pulse: seg 0x00 and min unchanged. Then a segDW pulse: seg 0x59.
- Load year 0x24, month 0x03, day 0x31, then monthDW: month 0x02, day 0x29. Repeat with year 0x23: day 0x28.
- Load day 0x31, month 0x01, then monthUP with `LEAP_EN`=0 and year 0x24: month 0x02, day 0x28. Load month 0x13, hour 0x2A: month 0x01, hour 0x00.
- Same-cycle edges:
  - hourUP and hourDW rising together: hour unchanged, `changed` stays 0.
  - minUP and dayDW together from day 0x01, month 0x04: min+1, day 0x30, one `changed` pulse.
- `load` and yearUP rising in the same cycle: loaded year wins. yearUP held through the load produces no later step. `reset` asserted mid-hold, then released: hour 0x00, and no step until the input toggles.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the RTC date/time holding registers.
// Field values are packed BCD throughout.
package rtc_pkg;

  localparam int SEG        = 0;
  localparam int MIN        = 1;
  localparam int HOUR       = 2;
  localparam int DAY        = 3;
  localparam int MONTH      = 4;
  localparam int YEAR       = 5;
  localparam int NUM_FIELDS = 6;

  localparam logic [7:0] SEG_MAX   = 8'h59;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] DAY_MAX   = 8'h31;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] YEAR_MAX  = 8'h99;

  localparam logic [7:0] SEG_RST   = 8'h00;
  localparam logic [7:0] MIN_RST   = 8'h00;
  localparam logic [7:0] HOUR_RST  = 8'h00;
  localparam logic [7:0] DAY_RST   = 8'h01;
  localparam logic [7:0] MONTH_RST = 8'h01;
  localparam logic [7:0] YEAR_RST  = 8'h00;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Year mod 4 from BCD digits: 10*hi contributes 2 when hi is odd, 0 when even.
  function automatic logic [7:0] dmax(input logic [7:0] month,
                                      input logic [7:0] year,
                                      input logic       leap_en);
    logic       leap;
    logic [7:0] r;
    leap = leap_en && (year[4] ? (year[1:0] == 2'b10) : (year[1:0] == 2'b00));
    case (month)
      8'h02:                      r = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One BCD field register: wrap-around step up/down, validated preload,
// and an optional upper clamp applied after the step or load.
module bcd_field_step
  import rtc_pkg::*;
#(
  parameter logic [7:0] RST_VAL  = 8'h00,
  parameter logic [7:0] LOAD_MAX = 8'h59,
  parameter bit         CLAMP_EN = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       dw,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  logic [7:0] clamp_max,
  output logic [7:0] field,
  output logic [7:0] next_value,
  output logic       stepped
);

  logic [7:0] step_val;
  logic [7:0] load_chk;

  always_comb begin
    step_val   = field;
    stepped    = 1'b0;
    load_chk   = RST_VAL;
    next_value = field;

    if (up && !dw) begin
      stepped  = 1'b1;
      step_val = (field >= max_val) ? min_val : bcd_inc(field);
    end else if (dw && !up) begin
      stepped  = 1'b1;
      step_val = ((field <= min_val) || (field > max_val)) ? max_val : bcd_dec(field);
    end

    if (bcd_valid(load_val) && (load_val >= min_val) && (load_val <= LOAD_MAX))
      load_chk = load_val;

    next_value = load ? load_chk : step_val;

    // Day only: pull back into the month's length after a month/year change or load.
    if (CLAMP_EN && (next_value > clamp_max))
      next_value = clamp_max;

    if (load)
      stepped = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) field <= RST_VAL;
    else       field <= next_value;
  end

endmodule

// File: rtl/rtc_field_counters.sv
// Six-field RTC setting bank: rising-edge detection of the level requests,
// per-field BCD stepping, calendar day clamp and validated preload.
module rtc_field_counters
  import rtc_pkg::*;
#(
  parameter bit LEAP_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_segUP,
  input  logic        count_minUP,
  input  logic        count_hourUP,
  input  logic        count_dayUP,
  input  logic        count_monthUP,
  input  logic        count_yearUP,
  input  logic        count_segDW,
  input  logic        count_minDW,
  input  logic        count_hourDW,
  input  logic        count_dayDW,
  input  logic        count_monthDW,
  input  logic        count_yearDW,
  input  logic        load,
  input  logic [47:0] load_data,
  output logic [7:0]  seg_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  year_bcd,
  output logic        changed
);

  logic [NUM_FIELDS-1:0] up_in, dw_in, up_prev, dw_prev, up_evt, dw_evt, stepped;
  logic [7:0]            next_vals [NUM_FIELDS];
  logic [7:0]            day_limit;
  logic [7:0]            day_clamp;

  assign up_in[SEG]   = count_segUP;
  assign up_in[MIN]   = count_minUP;
  assign up_in[HOUR]  = count_hourUP;
  assign up_in[DAY]   = count_dayUP;
  assign up_in[MONTH] = count_monthUP;
  assign up_in[YEAR]  = count_yearUP;
  assign dw_in[SEG]   = count_segDW;
  assign dw_in[MIN]   = count_minDW;
  assign dw_in[HOUR]  = count_hourDW;
  assign dw_in[DAY]   = count_dayDW;
  assign dw_in[MONTH] = count_monthDW;
  assign dw_in[YEAR]  = count_yearDW;

  assign up_evt = up_in & ~up_prev;
  assign dw_evt = dw_in & ~dw_prev;

  // Stepping uses today's month length; the clamp uses the month/year being written.
  assign day_limit = dmax(month_bcd, year_bcd, LEAP_EN);
  assign day_clamp = dmax(next_vals[MONTH], next_vals[YEAR], LEAP_EN);

  // History follows the inputs even through reset and load, so a held level never re-fires.
  always_ff @(posedge clock) begin
    up_prev <= up_in;
    dw_prev <= dw_in;
    if (reset) changed <= 1'b0;
    else       changed <= |stepped;
  end

  bcd_field_step #(.RST_VAL(SEG_RST), .LOAD_MAX(SEG_MAX), .CLAMP_EN(1'b0)) u_seg (
    .clock(clock), .reset(reset), .up(up_evt[SEG]), .dw(dw_evt[SEG]), .load(load),
    .load_val(load_data[7:0]), .min_val(SEG_RST), .max_val(SEG_MAX), .clamp_max(8'h00),
    .field(seg_bcd), .next_value(next_vals[SEG]), .stepped(stepped[SEG])
  );

  bcd_field_step #(.RST_VAL(MIN_RST), .LOAD_MAX(MIN_MAX), .CLAMP_EN(1'b0)) u_min (
    .clock(clock), .reset(reset), .up(up_evt[MIN]), .dw(dw_evt[MIN]), .load(load),
    .load_val(load_data[15:8]), .min_val(MIN_RST), .max_val(MIN_MAX), .clamp_max(8'h00),
    .field(min_bcd), .next_value(next_vals[MIN]), .stepped(stepped[MIN])
  );

  bcd_field_step #(.RST_VAL(HOUR_RST), .LOAD_MAX(HOUR_MAX), .CLAMP_EN(1'b0)) u_hour (
    .clock(clock), .reset(reset), .up(up_evt[HOUR]), .dw(dw_evt[HOUR]), .load(load),
    .load_val(load_data[23:16]), .min_val(HOUR_RST), .max_val(HOUR_MAX), .clamp_max(8'h00),
    .field(hour_bcd), .next_value(next_vals[HOUR]), .stepped(stepped[HOUR])
  );

  bcd_field_step #(.RST_VAL(DAY_RST), .LOAD_MAX(DAY_MAX), .CLAMP_EN(1'b1)) u_day (
    .clock(clock), .reset(reset), .up(up_evt[DAY]), .dw(dw_evt[DAY]), .load(load),
    .load_val(load_data[31:24]), .min_val(DAY_RST), .max_val(day_limit), .clamp_max(day_clamp),
    .field(day_bcd), .next_value(next_vals[DAY]), .stepped(stepped[DAY])
  );

  bcd_field_step #(.RST_VAL(MONTH_RST), .LOAD_MAX(MONTH_MAX), .CLAMP_EN(1'b0)) u_month (
    .clock(clock), .reset(reset), .up(up_evt[MONTH]), .dw(dw_evt[MONTH]), .load(load),
    .load_val(load_data[39:32]), .min_val(MONTH_RST), .max_val(MONTH_MAX), .clamp_max(8'h00),
    .field(month_bcd), .next_value(next_vals[MONTH]), .stepped(stepped[MONTH])
  );

  bcd_field_step #(.RST_VAL(YEAR_RST), .LOAD_MAX(YEAR_MAX), .CLAMP_EN(1'b0)) u_year (
    .clock(clock), .reset(reset), .up(up_evt[YEAR]), .dw(dw_evt[YEAR]), .load(load),
    .load_val(load_data[47:40]), .min_val(YEAR_RST), .max_val(YEAR_MAX), .clamp_max(8'h00),
    .field(year_bcd), .next_value(next_vals[YEAR]), .stepped(stepped[YEAR])
  );

endmodule

// File: tb/tb_rtc_field_counters.sv
// Bench for rtc_field_counters: fixed vector table, directed corner sequences and
// a randomized run against an arithmetic calendar model, for LEAP_EN=1 and LEAP_EN=0.
module tb_rtc_field_counters;

  logic        clock;
  logic        reset;
  logic [5:0]  up;
  logic [5:0]  dw;
  logic        load;
  logic [47:0] load_data;

  logic [7:0]  s1, mi1, h1, d1, mo1, y1, s0, mi0, h0, d0, mo0, y0;
  logic        ch1, ch0;
  logic [47:0] out1, out0;

  int errors = 0;
  int checks = 0;

  // Model state: index 1 = leap rule on, index 0 = leap rule off; fields as plain integers.
  int          mf [2][6];
  bit          mc [2];
  logic [5:0]  mup_prev, mdw_prev;

  typedef struct {
    logic [5:0]  up;
    logic [5:0]  dw;
    logic        load;
    logic [47:0] data;
    logic [47:0] exp_fields;
    logic        exp_changed;
  } vec_t;

  vec_t vecs [12];

  assign out1 = {y1, mo1, d1, h1, mi1, s1};
  assign out0 = {y0, mo0, d0, h0, mi0, s0};

  rtc_field_counters #(.LEAP_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .count_segUP(up[0]), .count_minUP(up[1]), .count_hourUP(up[2]),
    .count_dayUP(up[3]), .count_monthUP(up[4]), .count_yearUP(up[5]),
    .count_segDW(dw[0]), .count_minDW(dw[1]), .count_hourDW(dw[2]),
    .count_dayDW(dw[3]), .count_monthDW(dw[4]), .count_yearDW(dw[5]),
    .load(load), .load_data(load_data),
    .seg_bcd(s1), .min_bcd(mi1), .hour_bcd(h1), .day_bcd(d1), .month_bcd(mo1), .year_bcd(y1),
    .changed(ch1)
  );

  rtc_field_counters #(.LEAP_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .count_segUP(up[0]), .count_minUP(up[1]), .count_hourUP(up[2]),
    .count_dayUP(up[3]), .count_monthUP(up[4]), .count_yearUP(up[5]),
    .count_segDW(dw[0]), .count_minDW(dw[1]), .count_hourDW(dw[2]),
    .count_dayDW(dw[3]), .count_monthDW(dw[4]), .count_yearDW(dw[5]),
    .load(load), .load_data(load_data),
    .seg_bcd(s0), .min_bcd(mi0), .hour_bcd(h0), .day_bcd(d0), .month_bcd(mo0), .year_bcd(y0),
    .changed(ch0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lo_of(int i);
    return (i == 3 || i == 4) ? 1 : 0;
  endfunction

  function automatic int hi_of(int i);
    case (i)
      2:       return 23;
      3:       return 31;
      4:       return 12;
      5:       return 99;
      default: return 59;
    endcase
  endfunction

  function automatic int dmax_m(int mo, int yr, bit leap);
    if (mo == 2) return (leap && (yr % 4 == 0)) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] fld(int l, int i);
    logic [47:0] o;
    o = (l == 1) ? out1 : out0;
    return o[8*i +: 8];
  endfunction

  task automatic model_edge();
    logic [5:0] ue, de;
    logic [7:0] b;
    int v, lo, n, off, day_lim;
    bit any;
    ue = up & ~mup_prev;
    de = dw & ~mdw_prev;
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        for (int i = 0; i < 6; i++) mf[l][i] = lo_of(i);
        mc[l] = 1'b0;
      end else if (load) begin
        for (int i = 0; i < 6; i++) begin
          b = load_data[8*i +: 8];
          v = int'(b[7:4]) * 10 + int'(b[3:0]);
          if (b[7:4] < 10 && b[3:0] < 10 && v >= lo_of(i) && v <= hi_of(i)) mf[l][i] = v;
          else mf[l][i] = lo_of(i);
        end
        day_lim = dmax_m(mf[l][4], mf[l][5], l == 1);
        if (mf[l][3] > day_lim) mf[l][3] = day_lim;
        mc[l] = 1'b0;
      end else begin
        day_lim = dmax_m(mf[l][4], mf[l][5], l == 1);
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
          if (ue[i] != de[i]) begin
            lo  = lo_of(i);
            n   = ((i == 3) ? day_lim : hi_of(i)) - lo + 1;
            off = mf[l][i] - lo;
            off = ue[i] ? (off + 1) % n : (off + n - 1) % n;
            mf[l][i] = lo + off;
            any = 1'b1;
          end
        end
        day_lim = dmax_m(mf[l][4], mf[l][5], l == 1);
        if (mf[l][3] > day_lim) mf[l][3] = day_lim;
        mc[l] = any;
      end
    end
    mup_prev = up;
    mdw_prev = dw;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_val(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 6; i++)
        check_val($sformatf("%s leap%0d field%0d", tag, l, i), fld(l, i), to_bcd(mf[l][i]));
      check_val($sformatf("%s leap%0d changed", tag, l),
                {7'd0, (l == 1) ? ch1 : ch0}, {7'd0, mc[l]});
    end
  endtask

  task automatic set_idle();
    up = '0; dw = '0; load = 1'b0;
  endtask

  task automatic do_load(logic [47:0] data);
    load_data = data; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic apply_stimulus(vec_t v);
    up = v.up; dw = v.dw; load = v.load; load_data = v.data;
    tick();
  endtask

  task automatic check_output(int idx, vec_t v);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("vec%0d field%0d", idx, i), fld(1, i), v.exp_fields[8*i +: 8]);
    check_val($sformatf("vec%0d changed", idx), {7'd0, ch1}, {7'd0, v.exp_changed});
  endtask

  function automatic vec_t mk(logic [5:0] u, logic [5:0] d, logic ld, logic [47:0] data,
                              logic [47:0] ef, logic ec);
    vec_t v;
    v.up = u; v.dw = d; v.load = ld; v.data = data; v.exp_fields = ef; v.exp_changed = ec;
    return v;
  endfunction

  function automatic logic [7:0] rand_field(int i);
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return to_bcd($urandom_range(lo_of(i), hi_of(i)));
  endfunction

  initial begin
    int pulses;
    logic [47:0] rd;

    // Field order in the 48-bit words: {year, month, day, hour, min, seg}.
    vecs[0]  = mk(6'b000000, 6'b000000, 1'b1, 48'h24_03_31_12_34_56, 48'h24_03_31_12_34_56, 1'b0);
    vecs[1]  = mk(6'b000000, 6'b010000, 1'b0, 48'h0,                 48'h24_02_29_12_34_56, 1'b1);
    vecs[2]  = mk(6'b100000, 6'b000000, 1'b0, 48'h0,                 48'h25_02_28_12_34_56, 1'b1);
    vecs[3]  = mk(6'b001000, 6'b000000, 1'b0, 48'h0,                 48'h25_02_01_12_34_56, 1'b1);
    vecs[4]  = mk(6'b000000, 6'b001000, 1'b0, 48'h0,                 48'h25_02_28_12_34_56, 1'b1);
    vecs[5]  = mk(6'b000100, 6'b000100, 1'b0, 48'h0,                 48'h25_02_28_12_34_56, 1'b0);
    vecs[6]  = mk(6'b000010, 6'b000001, 1'b0, 48'h0,                 48'h25_02_28_12_35_55, 1'b1);
    vecs[7]  = mk(6'b000000, 6'b000000, 1'b1, 48'h9A_00_00_24_60_5A, 48'h00_01_01_00_00_00, 1'b0);
    vecs[8]  = mk(6'b000000, 6'b000100, 1'b0, 48'h0,                 48'h00_01_01_23_00_00, 1'b1);
    vecs[9]  = mk(6'b000000, 6'b010000, 1'b0, 48'h0,                 48'h00_12_01_23_00_00, 1'b1);
    vecs[10] = mk(6'b000000, 6'b000000, 1'b1, 48'h00_02_31_23_59_59, 48'h00_02_29_23_59_59, 1'b0);
    vecs[11] = mk(6'b000010, 6'b000000, 1'b0, 48'h0,                 48'h00_02_29_23_00_59, 1'b1);

    mup_prev = '0; mdw_prev = '0;
    set_idle(); load_data = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int l = 0; l < 2; l++) begin
      check_val($sformatf("reset leap%0d", l), {7'd0, (l == 1) ? ch1 : ch0}, 8'h00);
      for (int i = 0; i < 6; i++)
        check_val($sformatf("reset leap%0d field%0d", l, i), fld(l, i), (i == 3 || i == 4) ? 8'h01 : 8'h00);
    end

    for (int k = 0; k < 12; k++) begin
      apply_stimulus(vecs[k]);
      check_output(k, vecs[k]);
      set_idle();
      tick();
    end

    // Held segUP after reset gives exactly one step and one changed pulse.
    reset = 1'b1; tick(); reset = 1'b0;
    up[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ch1) pulses++;
      if (c == 0) check_val("hold seg first", s1, 8'h01);
    end
    check_val("hold seg final", s1, 8'h01);
    check_val("hold seg pulses", 8'(pulses), 8'd1);
    set_idle(); tick();

    // Seg wraps without touching min.
    do_load(48'h00_01_01_00_00_59);
    up[0] = 1'b1; tick();
    check_val("seg wrap up", s1, 8'h00);
    check_val("seg wrap min", mi1, 8'h00);
    up[0] = 1'b0; tick();
    dw[0] = 1'b1; tick();
    check_val("seg wrap down", s1, 8'h59);
    dw[0] = 1'b0; tick();

    // 31 March, month down: leap and non-leap years.
    do_load(48'h24_03_31_00_00_00);
    dw[4] = 1'b1; tick();
    check_val("mar31 y24 month", mo1, 8'h02);
    check_val("mar31 y24 day", d1, 8'h29);
    check_val("mar31 y24 day noleap", d0, 8'h28);
    dw[4] = 1'b0; tick();
    do_load(48'h23_03_31_00_00_00);
    dw[4] = 1'b1; tick();
    check_val("mar31 y23 day", d1, 8'h28);
    check_val("mar31 y23 day noleap", d0, 8'h28);
    dw[4] = 1'b0; tick();

    // Jan 31 month up in year 24 with the leap rule off, then out-of-range loads.
    do_load(48'h24_01_31_00_00_00);
    up[4] = 1'b1; tick();
    check_val("jan31 noleap month", mo0, 8'h02);
    check_val("jan31 noleap day", d0, 8'h28);
    check_val("jan31 leap day", d1, 8'h29);
    up[4] = 1'b0; tick();
    do_load(48'h24_13_01_2A_00_00);
    check_val("bad month", mo1, 8'h01);
    check_val("bad hour", h1, 8'h00);

    // Same-cycle edges.
    do_load(48'h00_04_01_05_10_00);
    up[2] = 1'b1; dw[2] = 1'b1; tick();
    check_val("hour updw", h1, 8'h05);
    check_val("hour updw changed", {7'd0, ch1}, 8'h00);
    set_idle(); tick();
    up[1] = 1'b1; dw[3] = 1'b1; tick();
    check_val("min+day min", mi1, 8'h11);
    check_val("min+day day", d1, 8'h30);
    check_val("min+day changed", {7'd0, ch1}, 8'h01);
    set_idle(); tick();
    check_val("min+day changed drop", {7'd0, ch1}, 8'h00);

    // Load beats a simultaneous yearUP; the held level never steps later.
    up[5] = 1'b1;
    do_load(48'h50_01_01_00_00_00);
    check_val("load vs yearup", y1, 8'h50);
    check_val("load changed", {7'd0, ch1}, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("year held", y1, 8'h50);
    end
    set_idle(); tick();

    // Reset in the middle of a held hourUP.
    up[2] = 1'b1; tick();
    check_val("hour before reset", h1, 8'h01);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("hour at reset", h1, 8'h00);
    for (int c = 0; c < 3; c++) tick();
    check_val("hour held after reset", h1, 8'h00);
    check_val("changed held after reset", {7'd0, ch1}, 8'h00);
    up[2] = 1'b0; tick();
    up[2] = 1'b1; tick();
    check_val("hour after retoggle", h1, 8'h01);
    set_idle(); tick();
    check_model("directed end");

    // Randomized traffic against the model, both leap settings.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) up = 6'($urandom) & 6'($urandom) & 6'($urandom);
      if ($urandom_range(0, 1) == 0) dw = 6'($urandom) & 6'($urandom) & 6'($urandom);
      load  = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 6; i++) rd[8*i +: 8] = rand_field(i);
      load_data = rd;
      tick();
      check_model("random");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
